drp_access_sequencer: RTL and testbench
=======================================

// Module: drp_access_sequencer
// PURPOSE
//  Sits directly downstream of the AXI-Lite register bridge. Consumes its single-cycle
//  w_occur/r_occur requests and runs one Xilinx-style DRP transaction per request on the
//  MMCM/ETS DRP port. Returns w_ready/r_valid completion pulses plus read data to the bridge.
//  Serialises accesses, guards against a dead DRP slave with a timeout and rejects
//  out-of-range addresses.
// PARAMETERS
//  ADDR_WIDTH      10   bridge word-address width
//  DATA_WIDTH      16   data width; bridge and DRP are equal
//  DRP_ADDR_WIDTH  7    DRP daddr width (ADDR_WIDTH >= DRP_ADDR_WIDTH)
//  TIMEOUT_CYCLES  64   max cycles after den without drdy before abort (>=2)
// PORTS
//  S_AXI_aclk     in   1               single clock, bridge and DRP
//  S_AXI_aresetn  in   1               asynchronous active-low reset
//  w_addr         in   ADDR_WIDTH      write word address from bridge
//  w_data         in   DATA_WIDTH      write data from bridge
//  w_occur        in   1               1-cycle write request pulse
//  r_addr         in   ADDR_WIDTH      read word address from bridge
//  r_occur        in   1               1-cycle read request pulse
//  w_ready        out  1               1-cycle write-complete pulse
//  r_valid        out  1               1-cycle read-complete pulse
//  r_data         out  DATA_WIDTH      read data; valid with r_valid, held until next read completes
//  drp_den        out  1               DRP enable, exactly 1 cycle per access
//  drp_dwe        out  1               DRP write enable, high only together with drp_den
//  drp_daddr      out  DRP_ADDR_WIDTH  DRP address
//  drp_di         out  DATA_WIDTH      DRP write data
//  drp_do         in   DATA_WIDTH      DRP read data, valid with drp_drdy
//  drp_drdy       in   1               DRP access done
//  drp_busy       out  1               high when state != IDLE
//  timeout_pulse  out  1               1-cycle pulse on each aborted access
//  timeout_count  out  8               saturating count of timeouts (sticks at 255)
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, pending flags and timeout counter cleared.
//  Capture: on w_occur, latch w_addr/w_data and set wr_pend. On r_occur, latch r_addr and set rd_pend.
//   - A new pulse while its own pend is already set overwrites the latched address/data (last wins).
//  FSM states: IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, DONE_W, DONE_R.
//  IDLE -> WR_REQ when wr_pend|w_occur; else -> RD_REQ when rd_pend|r_occur.
//   - Writes take priority on simultaneous or both-pending requests.
//  Range check: if latched address bits [ADDR_WIDTH-1:DRP_ADDR_WIDTH] != 0, no DRP access.
//   - Go straight to DONE_W / DONE_R instead; such a read returns 0.
//  WR_REQ (1 cycle): den=1, dwe=1, daddr/di from latch; clear wr_pend -> WR_WAIT.
//  RD_REQ (1 cycle): den=1, dwe=0; clear rd_pend -> RD_WAIT.
//  WR_WAIT/RD_WAIT: counter counts from 1.
//   - drdy=1 -> DONE_*; a read latches drp_do into r_data.
//   - Counter reaches TIMEOUT_CYCLES with no drdy -> timeout_pulse, timeout_count+1 -> DONE_*.
//   - A timed-out read returns all-ones.
//  DONE_W: w_ready=1 for one cycle -> IDLE. DONE_R: r_valid=1 for one cycle -> IDLE.
//  Latency: request edge N -> den in cycle N+1. drdy in cycle N+2 -> completion pulse in N+3 (minimum).
//  drdy outside *_WAIT is ignored. drdy in the same cycle as den is ignored; DRP drdy is never same-cycle.
//  A request arriving while busy is pended and served after return to IDLE, with no loss.
//  Outputs drp_daddr/drp_di hold last values when den=0. All outputs are registered.
//  Reset mid-access: everything returns to reset values immediately.
//   - Pending requests are discarded; no completion pulse is issued.
// TESTING
//  T1 write: w_addr=0x05, w_data=0xA5A5, w_occur; drdy 2 cycles after den.
//   -> one den+dwe, daddr=0x05, di=0xA5A5, single w_ready pulse.
//  T2 read: r_addr=0x12, r_occur; slave returns drp_do=0x1234 with drdy.
//   -> den with dwe=0, r_valid 1 cycle, r_data=0x1234 and held afterwards.
//  T3 simultaneous w_occur+r_occur on the same edge.
//   -> write DRP access first, then read; w_ready precedes r_valid; exactly 2 den pulses.
//  T4 drdy never asserted on a read.
//   -> after 64 wait cycles: timeout_pulse, r_valid with r_data=0xFFFF.
//   -> timeout_count=1; next access proceeds normally.
//  T5 w_addr=0x080 (bit 7 set) write.
//   -> no den, w_ready within 2 cycles; read of 0x3FF -> r_valid, r_data=0, no den.
//  T6 assert S_AXI_aresetn low during RD_WAIT with rd/wr pending.
//   -> all outputs 0, no completion pulse; after release, a fresh write completes normally.

Source files
------------

// File: rtl/drp_access_sequencer.sv
// drp_access_sequencer: serialises bridge read/write requests onto a DRP port,
// with write priority, an address range check and a drdy timeout.
module drp_access_sequencer #(
    parameter int ADDR_WIDTH     = 10,
    parameter int DATA_WIDTH     = 16,
    parameter int DRP_ADDR_WIDTH = 7,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                      S_AXI_aclk,
    input  logic                      S_AXI_aresetn,
    input  logic [ADDR_WIDTH-1:0]     w_addr,
    input  logic [DATA_WIDTH-1:0]     w_data,
    input  logic                      w_occur,
    input  logic [ADDR_WIDTH-1:0]     r_addr,
    input  logic                      r_occur,
    output logic                      w_ready,
    output logic                      r_valid,
    output logic [DATA_WIDTH-1:0]     r_data,
    output logic                      drp_den,
    output logic                      drp_dwe,
    output logic [DRP_ADDR_WIDTH-1:0] drp_daddr,
    output logic [DATA_WIDTH-1:0]     drp_di,
    input  logic [DATA_WIDTH-1:0]     drp_do,
    input  logic                      drp_drdy,
    output logic                      drp_busy,
    output logic                      timeout_pulse,
    output logic [7:0]                timeout_count
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, DONE_W, DONE_R} state_t;

    state_t                      state_q;
    logic                        wr_pend_q, rd_pend_q;
    logic [ADDR_WIDTH-1:0]       wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
    logic [DATA_WIDTH-1:0]       wr_data_q, wr_data_d;
    logic [CW-1:0]               cnt_q;
    logic                        w_ready_q, r_valid_q, den_q, dwe_q, busy_q, tpulse_q;
    logic [DATA_WIDTH-1:0]       r_data_q, di_q;
    logic [DRP_ADDR_WIDTH-1:0]   daddr_q;
    logic [7:0]                  tcount_q;
    logic                        wr_req, rd_req, wr_oor, rd_oor, wait_to;

    // A request pulse in the same cycle is used directly so den follows one cycle later.
    assign wr_addr_d = w_occur ? w_addr : wr_addr_q;
    assign wr_data_d = w_occur ? w_data : wr_data_q;
    assign rd_addr_d = r_occur ? r_addr : rd_addr_q;
    assign wr_req    = wr_pend_q | w_occur;
    assign rd_req    = rd_pend_q | r_occur;
    assign wr_oor    = (wr_addr_d >> DRP_ADDR_WIDTH) != '0;
    assign rd_oor    = (rd_addr_d >> DRP_ADDR_WIDTH) != '0;
    assign wait_to   = !drp_drdy && (cnt_q == CW'(TIMEOUT_CYCLES));

    always_ff @(posedge S_AXI_aclk or negedge S_AXI_aresetn) begin
        if (!S_AXI_aresetn) begin
            state_q   <= IDLE;
            wr_pend_q <= 1'b0;
            rd_pend_q <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            rd_addr_q <= '0;
            cnt_q     <= '0;
            w_ready_q <= 1'b0;
            r_valid_q <= 1'b0;
            r_data_q  <= '0;
            den_q     <= 1'b0;
            dwe_q     <= 1'b0;
            daddr_q   <= '0;
            di_q      <= '0;
            busy_q    <= 1'b0;
            tpulse_q  <= 1'b0;
            tcount_q  <= '0;
        end else begin
            den_q     <= 1'b0;
            dwe_q     <= 1'b0;
            w_ready_q <= 1'b0;
            r_valid_q <= 1'b0;
            tpulse_q  <= 1'b0;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            rd_addr_q <= rd_addr_d;
            if (w_occur) wr_pend_q <= 1'b1;
            if (r_occur) rd_pend_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (wr_req) begin
                        wr_pend_q <= 1'b0;
                        busy_q    <= 1'b1;
                        if (wr_oor) begin
                            state_q   <= DONE_W;
                            w_ready_q <= 1'b1;
                        end else begin
                            state_q <= WR_REQ;
                            den_q   <= 1'b1;
                            dwe_q   <= 1'b1;
                            daddr_q <= wr_addr_d[DRP_ADDR_WIDTH-1:0];
                            di_q    <= wr_data_d;
                        end
                    end else if (rd_req) begin
                        rd_pend_q <= 1'b0;
                        busy_q    <= 1'b1;
                        if (rd_oor) begin
                            state_q   <= DONE_R;
                            r_valid_q <= 1'b1;
                            r_data_q  <= '0;
                        end else begin
                            state_q <= RD_REQ;
                            den_q   <= 1'b1;
                            daddr_q <= rd_addr_d[DRP_ADDR_WIDTH-1:0];
                        end
                    end
                end
                WR_REQ: begin
                    state_q <= WR_WAIT;
                    cnt_q   <= CW'(1);
                end
                RD_REQ: begin
                    state_q <= RD_WAIT;
                    cnt_q   <= CW'(1);
                end
                WR_WAIT: begin
                    if (drp_drdy || wait_to) begin
                        state_q   <= DONE_W;
                        w_ready_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RD_WAIT: begin
                    if (drp_drdy || wait_to) begin
                        state_q   <= DONE_R;
                        r_valid_q <= 1'b1;
                        r_data_q  <= drp_drdy ? drp_do : '1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE_W, DONE_R: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
            if ((state_q == WR_WAIT || state_q == RD_WAIT) && wait_to) begin
                tpulse_q <= 1'b1;
                if (tcount_q != 8'hFF) tcount_q <= tcount_q + 8'd1;
            end
        end
    end

    assign w_ready       = w_ready_q;
    assign r_valid       = r_valid_q;
    assign r_data        = r_data_q;
    assign drp_den       = den_q;
    assign drp_dwe       = dwe_q;
    assign drp_daddr     = daddr_q;
    assign drp_di        = di_q;
    assign drp_busy      = busy_q;
    assign timeout_pulse = tpulse_q;
    assign timeout_count = tcount_q;
endmodule

// File: tb/tb_drp_access_sequencer.sv
// tb_drp_access_sequencer: directed bench with a behavioural DRP slave and an
// event scoreboard (den/w_ready/r_valid) filled as stimulus is driven.
module tb_drp_access_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [9:0]  w_addr = '0, r_addr = '0;
    logic [15:0] w_data = '0;
    logic        w_occur = 1'b0, r_occur = 1'b0;
    logic        w_ready, r_valid, drp_den, drp_dwe, drp_busy, timeout_pulse;
    logic [15:0] r_data, drp_di;
    logic [15:0] drp_do = '0;
    logic        drp_drdy = 1'b0;
    logic [6:0]  drp_daddr;
    logic [7:0]  timeout_count;

    typedef struct {
        int          kind;
        logic [15:0] addr;
        logic [15:0] data;
        logic        tp;
    } ev_t;

    ev_t         exp_q[$];
    int          checks = 0;
    int          passes = 0;
    int          slv_delay = 1;
    int          slv_cnt = 0;
    logic [15:0] slv_do = '0;

    drp_access_sequencer dut (
        .S_AXI_aclk(clk), .S_AXI_aresetn(rst_n),
        .w_addr(w_addr), .w_data(w_data), .w_occur(w_occur),
        .r_addr(r_addr), .r_occur(r_occur),
        .w_ready(w_ready), .r_valid(r_valid), .r_data(r_data),
        .drp_den(drp_den), .drp_dwe(drp_dwe), .drp_daddr(drp_daddr), .drp_di(drp_di),
        .drp_do(drp_do), .drp_drdy(drp_drdy), .drp_busy(drp_busy),
        .timeout_pulse(timeout_pulse), .timeout_count(timeout_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // kind: 0 = write den, 1 = read den, 2 = w_ready, 3 = r_valid
    function automatic void push(int kind, logic [15:0] a, logic [15:0] d, logic tp);
        ev_t e;
        e.kind = kind;
        e.addr = a;
        e.data = d;
        e.tp   = tp;
        exp_q.push_back(e);
    endfunction

    task automatic check_ev(input int kind, input logic [15:0] a, input logic [15:0] d, input logic tp);
        ev_t e;
        checks++;
        assert (exp_q.size() != 0) passes++;
        else $error("FAIL unexpected_event: observed kind %0d, expected no event", kind);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk($sformatf("event_kind_%0d", e.kind), 64'(kind), 64'(e.kind));
            if (kind < 2) chk("den_addr", 64'(a), 64'(e.addr));
            if (kind == 0 || kind == 3) chk($sformatf("data_kind_%0d", kind), 64'(d), 64'(e.data));
            if (kind >= 2) chk("completion_timeout_flag", 64'(tp), 64'(e.tp));
        end
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || drp_busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        assert (exp_q.size() == 0 && !drp_busy) passes++;
        else $error("FAIL %s_drain: observed %0d events outstanding busy=%0b, expected 0 and idle",
                    tag, exp_q.size(), drp_busy);
    endtask

    // Behavioural DRP slave: drdy slv_delay cycles after den (0 = never answers).
    always @(negedge clk) begin
        if (!rst_n) begin
            slv_cnt  = 0;
            drp_drdy = 1'b0;
        end else if (drp_den) begin
            slv_cnt  = slv_delay;
            drp_drdy = 1'b0;
            drp_do   = 16'hDEAD;
        end else if (slv_cnt > 0) begin
            slv_cnt--;
            drp_drdy = (slv_cnt == 0);
            drp_do   = drp_drdy ? slv_do : 16'hDEAD;
        end else begin
            drp_drdy = 1'b0;
            drp_do   = 16'hDEAD;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (drp_dwe) chk("dwe_only_with_den", 64'(drp_den), 64'd1);
            if (drp_den) check_ev(drp_dwe ? 0 : 1, {9'b0, drp_daddr}, drp_di, 1'b0);
            if (w_ready) check_ev(2, '0, '0, timeout_pulse);
            if (r_valid) check_ev(3, '0, r_data, timeout_pulse);
            if (timeout_pulse) chk("timeout_with_completion", 64'(w_ready | r_valid), 64'd1);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {w_ready, r_valid, r_data, drp_den, drp_dwe, drp_daddr, drp_di,
                              drp_busy, timeout_pulse, timeout_count}, 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // T1: write, drdy two cycles after den
        slv_delay = 2;
        w_addr = 10'h005; w_data = 16'hA5A5; w_occur = 1'b1;
        push(0, 16'h05, 16'hA5A5, 1'b0);
        push(2, '0, '0, 1'b0);
        @(negedge clk);
        w_occur = 1'b0;
        chk("t1_den_latency", 64'(drp_den), 64'd1);
        chk("t1_busy", 64'(drp_busy), 64'd1);
        repeat (3) @(negedge clk);
        chk("t1_w_ready_time", 64'(w_ready), 64'd1);
        @(negedge clk);
        chk("t1_w_ready_single", 64'(w_ready), 64'd0);
        drain("t1");

        // T2: read returning 0x1234, data held afterwards
        slv_delay = 1; slv_do = 16'h1234;
        @(negedge clk);
        r_addr = 10'h012; r_occur = 1'b1;
        push(1, 16'h12, '0, 1'b0);
        push(3, '0, 16'h1234, 1'b0);
        @(negedge clk);
        r_occur = 1'b0;
        drain("t2");
        repeat (5) @(negedge clk);
        chk("t2_r_data_held", 64'(r_data), 64'h1234);

        // T3: simultaneous write and read, write first
        slv_do = 16'h5A5A;
        w_addr = 10'h011; w_data = 16'hBEEF; w_occur = 1'b1;
        r_addr = 10'h022; r_occur = 1'b1;
        push(0, 16'h11, 16'hBEEF, 1'b0);
        push(2, '0, '0, 1'b0);
        push(1, 16'h22, '0, 1'b0);
        push(3, '0, 16'h5A5A, 1'b0);
        @(negedge clk);
        w_occur = 1'b0; r_occur = 1'b0;
        drain("t3");

        // T4: dead slave on a read, then a normal write
        slv_delay = 0;
        r_addr = 10'h020; r_occur = 1'b1;
        push(1, 16'h20, '0, 1'b0);
        push(3, '0, 16'hFFFF, 1'b1);
        @(negedge clk);
        r_occur = 1'b0;
        drain("t4");
        chk("t4_timeout_count", 64'(timeout_count), 64'd1);
        slv_delay = 1;
        w_addr = 10'h007; w_data = 16'h0F0F; w_occur = 1'b1;
        push(0, 16'h07, 16'h0F0F, 1'b0);
        push(2, '0, '0, 1'b0);
        @(negedge clk);
        w_occur = 1'b0;
        drain("t4_after");
        chk("t4_count_stable", 64'(timeout_count), 64'd1);

        // T5: out-of-range write and read, no DRP access
        w_addr = 10'h080; w_data = 16'h7777; w_occur = 1'b1;
        push(2, '0, '0, 1'b0);
        @(negedge clk);
        w_occur = 1'b0;
        chk("t5_w_ready_fast", 64'(w_ready), 64'd1);
        drain("t5_w");
        r_addr = 10'h3FF; r_occur = 1'b1;
        push(3, '0, 16'h0000, 1'b0);
        @(negedge clk);
        r_occur = 1'b0;
        chk("t5_r_valid_fast", 64'(r_valid), 64'd1);
        drain("t5_r");

        // T7: read request during a busy write is pended and served afterwards
        slv_delay = 3; slv_do = 16'h2222;
        w_addr = 10'h00A; w_data = 16'h1111; w_occur = 1'b1;
        push(0, 16'h0A, 16'h1111, 1'b0);
        push(2, '0, '0, 1'b0);
        @(negedge clk);
        w_occur = 1'b0;
        @(negedge clk);
        r_addr = 10'h00B; r_occur = 1'b1;
        push(1, 16'h0B, '0, 1'b0);
        push(3, '0, 16'h2222, 1'b0);
        @(negedge clk);
        r_occur = 1'b0;
        drain("t7");

        // T6: reset during RD_WAIT with both requests pending
        slv_delay = 0;
        r_addr = 10'h030; r_occur = 1'b1;
        push(1, 16'h30, '0, 1'b0);
        @(negedge clk);
        r_occur = 1'b0;
        repeat (3) @(negedge clk);
        w_addr = 10'h001; w_data = 16'h4444; w_occur = 1'b1;
        r_addr = 10'h002; r_occur = 1'b1;
        @(negedge clk);
        w_occur = 1'b0; r_occur = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t6_reset_outputs", {w_ready, r_valid, r_data, drp_den, drp_dwe, drp_daddr, drp_di,
                                 drp_busy, timeout_pulse, timeout_count}, 64'd0);
        chk("t6_queue_empty", 64'(exp_q.size()), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("t6_idle_after_reset", 64'(drp_busy), 64'd0);
        slv_delay = 2;
        w_addr = 10'h009; w_data = 16'h1357; w_occur = 1'b1;
        push(0, 16'h09, 16'h1357, 1'b0);
        push(2, '0, '0, 1'b0);
        @(negedge clk);
        w_occur = 1'b0;
        drain("t6_fresh");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
